// File: rtl/alu_pkg.sv
// Shared ALU types plus the interrupt-handler state and default sizing.
package alu_pkg;

  typedef logic [7:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WAIT_LOW
  } irq_hdl_state_t;

  localparam int IRQ_FIFO_DEPTH_DEF = 4;
  localparam int IRQ_CLR_CYCLES_DEF = 2;
  localparam int IRQ_TIMEOUT_DEF    = 16;

endpackage

// File: rtl/alu_evt_fifo.sv
// Show-ahead synchronous event FIFO; head reads as zero when empty.
module alu_evt_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && (count != '0);
  // A pop on the same edge frees the slot, so a full write still lands.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_irq_handler.sv
// ALU interrupt responder: capture, acknowledge, wait-low with timeout.
// Optional ALU_IRQ_TIMESTAMP_EN tags each entry with a 16-bit cycle stamp.
module alu_irq_handler
  import alu_pkg::*;
#(
  parameter int  FIFO_DEPTH     = IRQ_FIFO_DEPTH_DEF,
  parameter int  CLR_CYCLES     = IRQ_CLR_CYCLES_DEF,
  parameter int  TIMEOUT_CYCLES = IRQ_TIMEOUT_DEF,
  localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             alu_rst,
  input  logic             alu_irq,
  input  logic [7:0]       alu_out,
  output logic             alu_irq_clr,
  input  logic             evt_rd_en,
  output logic [7:0]       evt_data,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic             timeout_err,
  input  logic             sticky_clr
`ifdef ALU_IRQ_TIMESTAMP_EN
  ,
  output logic [15:0]      evt_timestamp
`endif
);

  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CLR_INIT = CW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef ALU_IRQ_TIMESTAMP_EN
  localparam int EW = 24;
`else
  localparam int EW = 8;
`endif

  irq_hdl_state_t state, state_n;
  logic [CW-1:0]  clr_cnt, clr_cnt_n;
  logic [TW-1:0]  wait_cnt, wait_cnt_n;
  logic           capture;
  logic           ovf_set;
  logic           tmo_set;
  logic           clr_n;
  logic           fifo_full;
  logic [EW-1:0]  wr_entry;
  logic [EW-1:0]  rd_entry;
  data_t          cap_data;

  assign cap_data = alu_out;

  always_ff @(posedge clk or negedge alu_rst) begin
    if (!alu_rst) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      clr_cnt  <= clr_cnt_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    clr_cnt_n  = clr_cnt;
    wait_cnt_n = wait_cnt;
    unique case (state)
      IDLE: begin
        if (alu_irq) begin
          state_n   = CLEAR;
          clr_cnt_n = CLR_INIT;
        end
      end
      CLEAR: begin
        if (clr_cnt == '0) begin
          state_n    = WAIT_LOW;
          wait_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt - 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!alu_irq) begin
          state_n = IDLE;
        end else if (wait_cnt == TMO_LAST) begin
          state_n   = CLEAR;
          clr_cnt_n = CLR_INIT;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    capture = (state == IDLE) && alu_irq;
    ovf_set = capture && fifo_full && !(evt_rd_en && evt_valid);
    tmo_set = (state == WAIT_LOW) && alu_irq && (wait_cnt == TMO_LAST);
    clr_n   = (state_n == CLEAR);
  end

  // Set beats a coincident sticky_clr.
  always_ff @(posedge clk or negedge alu_rst) begin
    if (!alu_rst) begin
      alu_irq_clr <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      alu_irq_clr <= clr_n;
      if (ovf_set)         overflow <= 1'b1;
      else if (sticky_clr) overflow <= 1'b0;
      if (tmo_set)         timeout_err <= 1'b1;
      else if (sticky_clr) timeout_err <= 1'b0;
    end
  end

`ifdef ALU_IRQ_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge clk or negedge alu_rst) begin
    if (!alu_rst) ts <= '0;
    else          ts <= ts + 1'b1;
  end

  assign wr_entry      = {ts, cap_data};
  assign evt_timestamp = rd_entry[23:8];
`else
  assign wr_entry = cap_data;
`endif

  assign evt_data  = rd_entry[7:0];
  assign evt_valid = (evt_count != '0);

  alu_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (alu_rst),
    .wr_en   (capture),
    .wr_data (wr_entry),
    .rd_en   (evt_rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .count   (evt_count)
  );

endmodule

// File: tb/tb_alu_irq_handler.sv
// Scoreboard bench for alu_irq_handler (default build, depth 4).
module tb_alu_irq_handler;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       alu_rst = 1'b0;
  logic       alu_irq = 1'b0;
  logic [7:0] alu_out = '0;
  logic       alu_irq_clr;
  logic       evt_rd_en = 1'b0;
  logic [7:0] evt_data;
  logic       evt_valid;
  logic [2:0] evt_count;
  logic       overflow;
  logic       timeout_err;
  logic       sticky_clr = 1'b0;
`ifdef ALU_IRQ_TIMESTAMP_EN
  logic [15:0] evt_timestamp;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] q[$];
  bit   ovf_m = 0;
  bit   tmo_m = 0;
  int   clr_hi;

  alu_irq_handler dut (
    .clk         (clk),
    .alu_rst     (alu_rst),
    .alu_irq     (alu_irq),
    .alu_out     (alu_out),
    .alu_irq_clr (alu_irq_clr),
    .evt_rd_en   (evt_rd_en),
    .evt_data    (evt_data),
    .evt_valid   (evt_valid),
    .evt_count   (evt_count),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .sticky_clr  (sticky_clr)
`ifdef ALU_IRQ_TIMESTAMP_EN
    ,
    .evt_timestamp (evt_timestamp)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    check("count", 32'(evt_count), 32'(q.size()));
    check("valid", 32'(evt_valid), 32'(q.size() != 0));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("timeout", 32'(timeout_err), 32'(tmo_m));
  endtask

  // One interrupt: capture edge, optional pop/sticky_clr on that edge.
  task automatic irq_evt(input logic [7:0] d, input int hold,
                         input bit rd, input bit sc);
    alu_irq    = 1'b1;
    alu_out    = d;
    evt_rd_en  = rd;
    sticky_clr = sc;
    if (rd && q.size() > 0) begin
      check("pop_head", 32'(evt_data), 32'(q[0]));
      void'(q.pop_front());
    end
    if (q.size() < DEPTH) q.push_back(d);
    else ovf_m = 1;
    if (sc && !(q.size() == DEPTH && ovf_m && !rd)) ovf_m = ovf_m;
    tick();
    evt_rd_en  = 1'b0;
    sticky_clr = 1'b0;
    check_state();
    repeat (hold - 1) tick();
    alu_irq = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pop();
    if (q.size() == 0) begin
      check("sb_underflow", 32'(1), 32'(0));
    end else begin
      check("valid_pop", 32'(evt_valid), 32'(1));
      check("data", 32'(evt_data), 32'(q.pop_front()));
    end
    evt_rd_en = 1'b1;
    tick();
    evt_rd_en = 1'b0;
    check("count_pop", 32'(evt_count), 32'(q.size()));
  endtask

  task automatic clear_sticky();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    ovf_m = 0;
    tmo_m = 0;
    check_state();
  endtask

  initial begin
    #12;
    check("rst_clr", 32'(alu_irq_clr), 32'(0));
    check("rst_data", 32'(evt_data), 32'(0));
    check_state();
    alu_rst = 1'b1;
    tick();

    // Single capture and acknowledge timing
    alu_irq = 1'b1;
    alu_out = 8'hFF;
    q.push_back(8'hFF);
    tick();
    check("clr_c1", 32'(alu_irq_clr), 32'(1));
    check_state();
    tick();
    check("clr_c2", 32'(alu_irq_clr), 32'(1));
    tick();
    check("clr_c3", 32'(alu_irq_clr), 32'(0));
    alu_irq = 1'b0;
    repeat (3) tick();
    check("data_ff", 32'(evt_data), 32'(8'hFF));
    check_state();
    pop();
    evt_rd_en = 1'b1;
    tick();
    evt_rd_en = 1'b0;
    check("empty_rd", 32'(evt_count), 32'(0));

    // Overflow with five events, then set-beats-clear
    irq_evt(8'h00, 3, 0, 0);
    irq_evt(8'hF8, 3, 0, 0);
    irq_evt(8'h83, 3, 0, 0);
    irq_evt(8'hF1, 3, 0, 0);
    irq_evt(8'hF4, 3, 0, 0);
    irq_evt(8'h55, 2, 0, 1);
    clear_sticky();
    for (int i = 0; i < DEPTH; i++) pop();

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < DEPTH; i++) irq_evt(8'(8'h10 + i), 1, 0, 0);
    irq_evt(8'hA5, 1, 1, 0);
    check("full_rw_cnt", 32'(evt_count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) pop();

    // Level held high: single capture plus timeout retries
    alu_irq = 1'b1;
    alu_out = 8'h3C;
    q.push_back(8'h3C);
    clr_hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (alu_irq_clr) clr_hi++;
      if (i == 10) check("tmo_early", 32'(timeout_err), 32'(0));
    end
    tmo_m = 1;
    check_state();
    check("clr_retry", 32'(clr_hi >= 4), 32'(1));
    alu_irq = 1'b0;
    repeat (4) tick();
    check_state();
    clear_sticky();
    pop();

    // Async reset in the middle of an acknowledge
    irq_evt(8'h21, 1, 0, 0);
    alu_irq = 1'b1;
    alu_out = 8'h22;
    tick();
    check("pre_rst_clr", 32'(alu_irq_clr), 32'(1));
    alu_rst = 1'b0;
    alu_irq = 1'b0;
    #1;
    check("rst_async_clr", 32'(alu_irq_clr), 32'(0));
    q.delete();
    ovf_m = 0;
    tmo_m = 0;
    check_state();
    #2;
    alu_rst = 1'b1;
    tick();
    irq_evt(8'h77, 1, 0, 0);
    pop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
